// File: rtl/tri_wave.sv
// Registered triangle-wave lookup: maps a 16-bit phase address to a triangle
// sample with one cycle of latency. Pure arithmetic, no internal phase state.
module tri_wave #(
  parameter int SIGNED_OUT = 0,
  parameter int AMP_SHIFT  = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_addr,
  output logic [15:0] o_data
);

  // No handshake: an address is accepted every cycle and its sample appears
  // on o_data after the next rising edge, independent of earlier addresses.

  logic [15:0] w_u;
  logic [15:0] w_s;
  logic [15:0] w_o;
  logic [15:0] r_data;

  // Falling half mirrors the rising half so peak and trough each hold for two
  // addresses and the 0xFFFF -> 0x0000 wrap is seamless.
  always_comb begin
    w_u = '0;
    if (i_addr[15]) begin
      w_u = {~i_addr[14:0], 1'b0};
    end else begin
      w_u = {i_addr[14:0], 1'b0};
    end
  end

  always_comb begin
    w_s = w_u;
    w_o = '0;
    if (SIGNED_OUT != 0) begin
      w_s = {~w_u[15], w_u[14:0]};
      w_o = $signed(w_s) >>> AMP_SHIFT;
    end else begin
      w_o = w_s >> AMP_SHIFT;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
    end else begin
      r_data <= w_o;
    end
  end

  assign o_data = r_data;

endmodule

// File: tb/tb_tri_wave.sv
// Bench for tri_wave: six parameter variants share one address stream; a
// scoreboard queue holds expected samples checked one cycle after each address.
module tb_tri_wave;

  localparam int N = 6;
  // Variant g: signed flag SGV[g], shift SHV[g*4 +: 4]
  localparam logic [5:0]  SGV = 6'b101010;
  localparam logic [23:0] SHV = {4'd15, 4'd15, 4'd1, 4'd1, 4'd0, 4'd0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = 16'h4000;
  logic [15:0] dout [N];

  int checks = 0;
  int errors = 0;

  logic [N*16-1:0] exp_q[$];
  logic [17:0]     addr_q[$];   // {pass2, sweep, addr}
  logic [15:0]     first_pass [int];

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    tri_wave #(
      .SIGNED_OUT(int'(SGV[g])),
      .AMP_SHIFT (int'(SHV[g*4 +: 4]))
    ) u_dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .i_addr (addr),
      .o_data (dout[g])
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_tri(input logic [15:0] a, input int sgn, input int sh);
    int u;
    int r;
    if (a < 16'h8000) u = 2 * int'(a);
    else              u = 2 * (65535 - int'(a));
    if (sgn != 0) r = (u - 32768) >>> sh;
    else          r = u >> sh;
    return r[15:0];
  endfunction

  function automatic logic [N*16-1:0] ref_all(input logic [15:0] a);
    logic [N*16-1:0] v;
    v = '0;
    for (int g = 0; g < N; g++) v[g*16 +: 16] = ref_tri(a, int'(SGV[g]), int'(SHV[g*4 +: 4]));
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [15:0] a, input logic sweep, input logic pass2);
    @(negedge clk);
    addr = a;
    exp_q.push_back(ref_all(a));
    addr_q.push_back({pass2, sweep, a});
  endtask

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, want);
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int g = 0; g < N; g++) check_val($sformatf("%s[%0d]", name, g), dout[g], 16'h0000);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [15:0] prev_addr;
  logic [15:0] prev_out;
  logic        prev_sweep = 1'b0;

  always begin
    logic [N*16-1:0] e;
    logic [17:0]     ai;
    int              d;
    int              want_d;
    @(posedge clk);
    if (exp_q.size() > 0) begin
      #1;
      e  = exp_q.pop_front();
      ai = addr_q.pop_front();
      for (int g = 0; g < N; g++)
        check_val($sformatf("model[%0d] addr=%h", g, ai[15:0]), dout[g], e[g*16 +: 16]);
      if (ai[16]) begin
        if (prev_sweep && ai[15:0] == prev_addr + 16'd1) begin
          d = int'(dout[0]) - int'(prev_out);
          if (prev_addr == 16'h7FFF || prev_addr == 16'hFFFF) want_d = 0;
          else if (!prev_addr[15])                            want_d = 2;
          else                                                want_d = -2;
          checks++;
          if (d != want_d) begin
            errors++;
            $display("FAIL sweep_step addr=%h got_diff=%0d exp_diff=%0d", ai[15:0], d, want_d);
          end
        end
        if (!ai[17]) begin
          first_pass[int'(ai[15:0])] = dout[0];
        end else if (first_pass.exists(int'(ai[15:0]))) begin
          check_val($sformatf("period2 addr=%h", ai[15:0]), dout[0], first_pass[int'(ai[15:0])]);
        end
      end
      prev_sweep = ai[16];
      prev_addr  = ai[15:0];
      prev_out   = dout[0];
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] k_addr [13] = '{16'h0000, 16'h4000, 16'h7FFF, 16'h8000, 16'hC000, 16'hFFFF,
                               16'h0000, 16'h4000, 16'h7FFF, 16'hFFFF,
                               16'h7FFF, 16'h0000, 16'h7FFF};
  int          k_inst [13] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 3, 3};
  logic [15:0] k_exp  [13] = '{16'h0000, 16'h8000, 16'hFFFE, 16'hFFFE, 16'h7FFE, 16'h0000,
                               16'h8000, 16'h0000, 16'h7FFE, 16'h8000,
                               16'h7FFF, 16'hC000, 16'h3FFF};

  initial begin
    int rnd;
    int budget;

    // Reset held with a nonzero address
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_hold");

    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(ref_all(addr));
    addr_q.push_back({2'b00, addr});
    @(posedge clk);
    #1;
    check_val("first_after_reset", dout[0], 16'h8000);

    // Directed key points
    for (int i = 0; i < 13; i++) begin
      drive(k_addr[i], 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_val($sformatf("key addr=%h inst=%0d", k_addr[i], k_inst[i]), dout[k_inst[i]], k_exp[i]);
    end

    // Reset asserted between edges clears output at once
    drive(16'h7FFF, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep windows around peak and wrap, two periods
    for (int p = 0; p < 2; p++) begin
      for (int w = 0; w < 2; w++) begin
        for (int i = 0; i < 512; i++) begin
          drive(((w == 0) ? 16'h7F00 : 16'hFF00) + 16'(i), 1'b1, p[0]);
        end
      end
    end

    // Random jumps, with occasional boundary addresses
    for (int i = 0; i < 1000; i++) begin
      rnd = $urandom_range(0, 9);
      case (rnd)
        0:       drive(16'h0000, 1'b0, 1'b0);
        1:       drive(16'hFFFF, 1'b0, 1'b0);
        2:       drive(16'h7FFF + 16'($urandom_range(0, 1)), 1'b0, 1'b0);
        default: drive(16'($urandom_range(0, 65535)), 1'b0, 1'b0);
      endcase
    end

    // Drain the scoreboard with a bounded wait
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tri_wave.md
Name: tri_wave

Overview:
- Registered triangle-wave lookup for the synth oscillator path.
- Maps a 16-bit phase address (normally driven by a free-running phase counter) to a 16-bit triangle sample.
- Pure arithmetic: no ROM and no internal phase state.
- One address per clock, one sample out per clock, fixed 1-cycle latency.

Parameters:
- SIGNED_OUT, 0, output format. 0 = unsigned (0x0000 min, 0xFFFE peak); 1 = two's complement, centred on zero.
- AMP_SHIFT, 0, amplitude attenuation as a right shift. Legal range 0..15. Logical shift when unsigned, arithmetic shift when signed.

Ports:
- i_clk  input  1  system clock (5 MHz in the synth, not timing-critical)
- i_rst_n  input  1  asynchronous active-low reset
- i_addr  input  16  phase address: 0x0000..0x7FFF rising half, 0x8000..0xFFFF falling half
- o_data  output  16  registered triangle sample

Behaviour:
- Reset: while i_rst_n = 0, o_data = 0x0000 immediately (asynchronous), regardless of SIGNED_OUT. First valid sample appears on the first rising i_clk edge after i_rst_n deasserts. Reset asserted mid-stream clears o_data at once; there is no other state.
- Core value u (16-bit unsigned), computed combinationally from i_addr:
  - i_addr[15] = 0: u = {i_addr[14:0], 1'b0} (rising, 0x0000 to 0xFFFE, step 2)
  - i_addr[15] = 1: u = {~i_addr[14:0], 1'b0} (falling, 0xFFFE to 0x0000, step 2)
- Waveform continuity:
  - Peak held for two addresses: 0x7FFF and 0x8000 both give 0xFFFE.
  - Trough held for two addresses: 0xFFFF and 0x0000 both give 0x0000.
  - A full 65536-address sweep is one symmetric period. Wrap 0xFFFF to 0x0000 is seamless.
- Format:
  - SIGNED_OUT = 0: s = u.
  - SIGNED_OUT = 1: s = u with MSB inverted (offset binary to two's complement). Range is 0x8000 (-32768) to 0x7FFE (+32766).
- Attenuation:
  - Unsigned: o = s >> AMP_SHIFT, zero-filled.
  - Signed: o = s >>> AMP_SHIFT, sign-extended.
- Latency: o_data is updated with o on every rising i_clk edge (no enable). A sample for address A is visible one cycle after A is sampled.
- Any i_addr sequence is legal. Arbitrary jumps produce the mapped value with no history dependence.
- No X propagation: every output bit is defined from reset onward.
- Synthesizable with no multipliers and no memories.

Test Plan:
- Reset: hold i_rst_n = 0 with i_addr = 0x4000 -> o_data = 0x0000. Release; the next edge gives 0x8000. Re-assert between edges -> o_data = 0x0000 immediately.
- Key points (SIGNED_OUT = 0, AMP_SHIFT = 0), each checked one cycle after the address:
  - 0x0000 -> 0x0000
  - 0x4000 -> 0x8000
  - 0x7FFF -> 0xFFFE
  - 0x8000 -> 0xFFFE
  - 0xC000 -> 0x7FFE
  - 0xFFFF -> 0x0000
- Full sweep: drive i_addr from a wrapping counter 0..65535 for two periods.
  - Adjacent outputs differ by exactly 2.
  - Exceptions: differences of 0 at 0x7FFF->0x8000 and at 0xFFFF->0x0000.
  - Second period is identical to the first.
- Signed mode (SIGNED_OUT = 1):
  - 0x0000 -> 0x8000
  - 0x4000 -> 0x0000
  - 0x7FFF -> 0x7FFE
  - 0xFFFF -> 0x8000
- Attenuation:
  - SIGNED_OUT = 0, AMP_SHIFT = 1: 0x7FFF -> 0x7FFF.
  - SIGNED_OUT = 1, AMP_SHIFT = 1: 0x0000 -> 0xC000 and 0x7FFF -> 0x3FFF.
- Random jumps: 1000 random addresses, checked against a reference model of the mapping with 1-cycle latency -> zero mismatches.
